// File: rtl/tff_count_ctrl_pkg.sv
// Shared types and constants for the T-FF up/down counter controller.
package tff_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_count_ctrl_bank.sv
// Bank of WIDTH toggle flip-flops; q flips wherever t is high on the rising edge.
module tff_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else       q <= q ^ t;
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequences a T-FF bank as a programmable up/down counter with load, run-to-limit and status pulses.
module tff_count_ctrl
  import tff_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             busy_d, done_d, wrap_d;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] up_t, dn_t;

  // Ripple-free toggle terms: bit i flips when all lower bits are ones (up) or zeros (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_tog
    assign up_t[i] = &count[i-1:0];
    assign dn_t[i] = ~|count[i-1:0];
  end

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clock (clock),
    .reset (reset),
    .t     (toggle),
    .q     (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      limit_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
      busy    <= busy_d;
      done    <= done_d;
      wrap    <= wrap_d;
    end
  end

  // Next state, toggle vector and next values of the registered status flags.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    limit_d = limit_q;
    toggle  = '0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          toggle = count ^ load_val;
        end else if (start) begin
          dir_d   = dir;
          limit_d = limit;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (count != limit_q) begin
          if (dir_q == DIR_UP) begin
            toggle = up_t;
            wrap_d = &count;
          end else begin
            toggle = dn_t;
            wrap_d = ~|count;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Self-checking bench: directed vector table, reset corner cases and a random run against a reference model.
module tb_tff_count_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy, done, wrap;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  tff_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .dir      (dir),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       dr;
    logic [7:0] lim;
    logic [7:0] ec;
    logic       eb;
    logic       ed;
    logic       ew;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: run length is computed once at start, then counted down.
  int m_state;   // 0 idle, 1 run, 2 done
  int m_count;
  int m_dir;
  int m_left;
  int m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic [7:0] lv, input logic st, input logic dr,
                     input logic [7:0] lim, input logic [7:0] ec, input logic eb,
                     input logic ed, input logic ew);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.dr = dr; v.lim = lim;
    v.ec = ec; v.eb = eb; v.ed = ed; v.ew = ew;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic rs, input logic ld, input logic [7:0] lv, input logic st,
                       input logic dr, input logic [7:0] lim);
    reset = rs; load = ld; load_val = lv; start = st; dir = dr; limit = lim;
    @(posedge clock);
    #1;
  endtask

  task automatic model_step(input logic rs, input logic ld, input logic [7:0] lv,
                            input logic st, input logic dr, input logic [7:0] lim);
    m_wrap = 0;
    if (rs) begin
      m_state = 0; m_count = 0; m_dir = 1; m_left = 0;
    end else begin
      case (m_state)
        0: begin
          if (ld) begin
            m_count = int'(lv);
          end else if (st) begin
            m_dir   = int'(dr);
            m_left  = dr ? ((int'(lim) - m_count) % 256 + 256) % 256
                         : ((m_count - int'(lim)) % 256 + 256) % 256;
            m_state = 1;
          end
        end
        1: begin
          if (m_left > 0) begin
            if (m_dir == 1) begin
              if (m_count == 255) m_wrap = 1;
              m_count = (m_count + 1) % 256;
            end else begin
              if (m_count == 0) m_wrap = 1;
              m_count = (m_count + 255) % 256;
            end
            m_left--;
          end else begin
            m_state = 2;
          end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  initial begin
    // Power-on reset for two cycles
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
      chk("reset_count", 32'(count), 32'h0);
      chk("reset_flags", 32'({busy, done, wrap}), 32'h0);
    end

    // Test 2: load 0x05, count up to 0x08
    add(1, 8'h05, 0, 1, 8'h00, 8'h05, 0, 0, 0);
    add(0, 8'h00, 1, 1, 8'h08, 8'h05, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h06, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h07, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h08, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h08, 0, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h08, 0, 0, 0);
    // Test 3: up through the 0xFF -> 0x00 wrap
    add(1, 8'hFE, 0, 1, 8'h00, 8'hFE, 0, 0, 0);
    add(0, 8'h00, 1, 1, 8'h01, 8'hFE, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 0, 0);
    // Test 4: down through the 0x00 -> 0xFF wrap
    add(1, 8'h01, 0, 1, 8'h00, 8'h01, 0, 0, 0);
    add(0, 8'h00, 1, 0, 8'hFE, 8'h01, 1, 0, 0);
    add(0, 8'h00, 0, 1, 8'h00, 8'h00, 1, 0, 0);
    add(0, 8'h00, 0, 1, 8'h00, 8'hFF, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'h00, 8'hFE, 1, 0, 0);
    add(0, 8'h00, 0, 1, 8'h00, 8'hFE, 0, 1, 0);
    add(0, 8'h00, 0, 1, 8'h00, 8'hFE, 0, 0, 0);
    // Test 5: limit equals count, zero steps
    add(1, 8'h10, 0, 1, 8'h00, 8'h10, 0, 0, 0);
    add(0, 8'h00, 1, 1, 8'h10, 8'h10, 1, 0, 0);
    add(0, 8'h00, 0, 1, 8'h00, 8'h10, 0, 1, 0);
    add(0, 8'h00, 0, 1, 8'h00, 8'h10, 0, 0, 0);
    // Test 6: load beats start; start/load ignored in RUN and DONE
    add(1, 8'h33, 1, 1, 8'h40, 8'h33, 0, 0, 0);
    add(0, 8'h00, 1, 1, 8'h36, 8'h33, 1, 0, 0);
    add(1, 8'h00, 1, 0, 8'h99, 8'h34, 1, 0, 0);
    add(1, 8'hAA, 1, 0, 8'h11, 8'h35, 1, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h36, 1, 0, 0);
    add(0, 8'h00, 1, 0, 8'h00, 8'h36, 0, 1, 0);
    add(1, 8'h77, 1, 0, 8'h00, 8'h36, 0, 0, 0);
    add(0, 8'h00, 0, 0, 8'h00, 8'h36, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(1'b0, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].dr, vecs[i].lim);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_flags", i), 32'({busy, done, wrap}),
          32'({vecs[i].eb, vecs[i].ed, vecs[i].ew}));
    end

    // Reset in the middle of a run: clears everything, no done pulse afterwards
    apply(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);
    apply(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80);
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("midrun_count", 32'(count), 32'h5);
    chk("midrun_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("midrun_reset_count", 32'(count), 32'h0);
      chk("midrun_reset_flags", 32'({busy, done, wrap}), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("post_reset_count", 32'(count), 32'h0);
      chk("post_reset_flags", 32'({busy, done, wrap}), 32'h0);
    end

    // Randomised traffic against the reference model
    m_state = 0; m_count = 0; m_dir = 1; m_left = 0; m_wrap = 0;
    for (int i = 0; i < 4000; i++) begin
      logic       rs, ld, st, dr;
      logic [7:0] lv, lim;
      rs  = ($urandom_range(0, 299) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 2) == 0);
      dr  = 1'($urandom);
      lv  = 8'($urandom);
      lim = ($urandom_range(0, 1) == 0) ? 8'(lv + 8'($urandom_range(0, 6))) : 8'($urandom);
      apply(rs, ld, lv, st, dr, lim);
      model_step(rs, ld, lv, st, dr, lim);
      chk("rand_count", 32'(count), 32'(m_count));
      chk("rand_flags", 32'({busy, done, wrap}),
          32'({(m_state == 1), (m_state == 2), (m_wrap == 1)}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tff_count_ctrl.md
Name: tff_count_ctrl

Overview:
- Controller that sequences a bank of T flip-flops as a programmable synchronous up/down counter.
- Each cycle it computes the per-bit toggle vector from the current bank state and the active command: load, run a step, or hold.
- A host issues a load or a start/limit command and receives busy and done status. The block sits between control logic and the T-FF storage bank.

Parameters:
- WIDTH, 8, number of T-FF bits in the bank (counter width, >=2).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  load request; sampled in IDLE only.
- load_val  input  WIDTH  value to load.
- start  input  1  run request; sampled in IDLE only.
- dir  input  1  1 = count up, 0 = count down; latched on start.
- limit  input  WIDTH  terminal count; latched on start.
- count  output  WIDTH  current bank state (T-FF Q vector).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- wrap  output  1  one-cycle pulse on the edge where count wraps.

Behaviour:
- Interface (already decided): one clock, named clock; reset is synchronous and active-high, named reset.
- Reset: count=0, busy=0, done=0, wrap=0, state=IDLE, dir_q=1, limit_q=0.
  - Reset overrides everything, including mid-RUN; no done pulse is produced.
- Toggle generation (combinational), with T[i] as the toggle input of bank bit i:
  - Up step: T[0]=1; T[i]=&count[i-1:0].
  - Down step: T[0]=1; T[i]=&~count[i-1:0].
  - Load: T = count ^ load_val.
  - Hold: T = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - load=1: apply load toggles; count=load_val after the edge; stay in IDLE.
  - load=1 and start=1 in the same cycle: load wins, start is dropped.
  - start=1 (load=0): latch dir and limit, go to RUN; busy=1 after the edge; no step on this edge.
- RUN:
  - If count != limit_q: step one in dir_q on each edge.
  - If count == limit_q: hold; go to DONE.
  - start and load are ignored while in RUN.
- DONE: done=1 and busy=0 for exactly one cycle; hold; return to IDLE. start and load are ignored.
- Timing: start sampled on edge k with initial count c0. Let n = (limit - c0) mod 2^WIDTH for up, or (c0 - limit) mod 2^WIDTH for down.
  - Steps occur on edges k+1..k+n.
  - DONE is entered on edge k+n+1.
  - IDLE is re-entered on edge k+n+2.
  - busy is high for n+1 cycles.
- Wrap: an up step from all-ones to 0, or a down step from 0 to all-ones, pulses wrap=1 for the cycle following that edge.
  - A load never raises wrap.
- Arithmetic: modulo 2^WIDTH with no saturation. A full-circle run (n = 2^WIDTH - 1) is legal.

Decomposition:
- Shared package: the state enum (IDLE, RUN, DONE) and the DIR_UP/DIR_DOWN constants.
- One natural sub-module: tff_bank. It holds WIDTH T-FFs with a synchronous active-high reset that clears Q, and has ports clock, reset, T[WIDTH], Q[WIDTH].
- The controller instantiates tff_bank and contains only the FSM and the toggle logic.

Test Plan (WIDTH=8):
1. Assert reset for 2 cycles, including once mid-RUN -> count=0x00, busy=0, done=0, wrap=0, FSM in IDLE the next cycle; no done pulse.
2. load 0x05, then start with dir=1, limit=0x08 -> count 0x06, 0x07, 0x08 on successive edges; busy high for 4 cycles; done pulses once; then IDLE with count=0x08.
3. load 0xFE, start up with limit=0x01 -> count 0xFF, 0x00 (wrap=1 for that cycle), 0x01; done; wrap pulses exactly once.
4. load 0x01, start with dir=0, limit=0xFE -> count 0x00, 0xFF (wrap=1), 0xFE; done.
5. load 0x10, start with limit=0x10 -> busy for 1 cycle, done next cycle, count stays 0x10, zero steps.
6. Assert load=1 (0x33) and start=1 together in IDLE -> count=0x33, busy stays 0. Then pulse start and load during RUN -> both ignored, run completes unchanged.
